// File: rtl/mips_defs.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and default streak limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_defs;

    // Consecutive data grants allowed while a fetch is waiting.
    localparam int DEF_MAX_DATA_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of data grants won while a fetch was waiting; sat gives fetch priority.
// Latency: count updates on the clock edge after inc/clr; sat is a direct compare of the count.
// Backpressure: none; clr wins over inc, inc is ignored once saturated.
// Ports: clk, rst_n (async active-low), inc, clr inputs; sat output.
module arb_streak_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat = (cnt_q == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory; data wins unless fetch is starved.
// Latency: request in IDLE cycle N, mem_ready in N+1 -> done pulse and rdata in N+2; waits indefinitely on mem_ready.
// Backpressure: mem_stall holds the pipeline while any request is outstanding and not yet completed.
// Ports: if_req/if_addr -> if_rdata/if_done; dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_done;
//        mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ready; mem_stall to hazard logic.
module mem_port_arbiter
    import mips_defs::*;
#(
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int AW              = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [AW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [AW-1:0] dm_wdata,
    output logic [AW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          mem_stall
);

    arb_state_t state_q, state_d;
    logic       if_elig, dm_elig;
    logic       gnt_i, gnt_d;
    logic       streak_sat;

    // A request whose done pulse is showing has just been served; the req
    // still high in that cycle belongs to it and must not be granted again.
    assign if_elig = if_req & ~if_done;
    assign dm_elig = dm_req & ~dm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dm_elig && !(if_elig && streak_sat)) begin
                    gnt_d   = 1'b1;
                    state_d = BUSY_D;
                end else if (if_elig) begin
                    gnt_i   = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    arb_streak_ctr #(
        .MAX (MAX_DATA_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (gnt_d & if_req),
        .clr   (gnt_i | (gnt_d & ~if_req)),
        .sat   (streak_sat)
    );

    // Request fields are captured at grant and stay frozen for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if (gnt_d) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (gnt_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
            if (state_q == BUSY_I && mem_ready) begin
                if_rdata <= mem_rdata;
                if_done  <= 1'b1;
            end
            // Writes load dm_rdata too; the pipeline simply ignores it.
            if (state_q == BUSY_D && mem_ready) begin
                dm_rdata <= mem_rdata;
                dm_done  <= 1'b1;
            end
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_stall = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [AW-1:0] if_rdata;
    logic          if_done;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [AW-1:0] dm_wdata;
    logic [AW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] mem_wdata;
    logic [AW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_stall;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .MAX_DATA_STREAK (4),
        .AW              (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_stall (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int dg;
        int dg_at_fetch;
        logic seen_i;
        logic [31:0] streak_at_fetch;

        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_if_done",  32'(if_done),  32'd0);
        chk("rst_dm_done",  32'(dm_done),  32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        chk("rst_wdata",    mem_wdata,     32'd0);
        chk("rst_if_rdata", if_rdata,      32'd0);
        chk("rst_dm_rdata", dm_rdata,      32'd0);
        step;
        rst_n = 1'b1;

        // Fetch only, minimum latency; req held through done cycle
        if_req  = 1'b1;
        if_addr = 32'h40;
        #1 chk("f_stall_req", 32'(mem_stall), 32'd1);
        step;
        chk("f_mem_req",  32'(mem_req), 32'd1);
        chk("f_mem_addr", mem_addr,     32'h40);
        chk("f_mem_we",   32'(mem_we),  32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h8C010004;
        step;
        chk("f_if_done",  32'(if_done), 32'd1);
        chk("f_if_rdata", if_rdata,     32'h8C010004);
        chk("f_req_idle", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;
        #1 chk("f_stall_done", 32'(mem_stall), 32'd0);
        step;
        chk("f_no_regrant", 32'(mem_req), 32'd0);
        chk("f_done_once",  32'(if_done), 32'd0);
        if_req = 1'b0;
        step;

        // Contention: data first, fetch granted in the dm_done cycle
        if_req   = 1'b1;
        if_addr  = 32'h44;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h100;
        dm_wdata = 32'hAB;
        step;
        chk("c_d_addr",  mem_addr,     32'h100);
        chk("c_d_we",    32'(mem_we),  32'd1);
        chk("c_d_wdata", mem_wdata,    32'hAB);
        chk("c_stall1",  32'(mem_stall), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h55;
        step;
        chk("c_dm_done",  32'(dm_done), 32'd1);
        chk("c_dm_rdata", dm_rdata,     32'h55);
        chk("c_stall2",   32'(mem_stall), 32'd1);
        mem_ready = 1'b0;
        step;
        chk("c_i_req",  32'(mem_req), 32'd1);
        chk("c_i_addr", mem_addr,     32'h44);
        chk("c_i_we",   32'(mem_we),  32'd0);
        dm_req = 1'b0;
        #1 chk("c_stall3", 32'(mem_stall), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234;
        step;
        chk("c_if_done",  32'(if_done), 32'd1);
        chk("c_if_rdata", if_rdata,     32'h1234);
        chk("c_stall4",   32'(mem_stall), 32'd0);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step;

        // Wait states on a data write
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h200;
        dm_wdata = 32'hCAFE;
        step;
        for (int k = 0; k < 5; k++) begin
            chk("w_addr",  mem_addr,       32'h200);
            chk("w_wdata", mem_wdata,      32'hCAFE);
            chk("w_req",   32'(mem_req),   32'd1);
            chk("w_nodone", 32'(dm_done),  32'd0);
            chk("w_stall", 32'(mem_stall), 32'd1);
            step;
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        step;
        chk("w_done",   32'(dm_done), 32'd1);
        chk("w_rdata",  dm_rdata,     32'h77);
        dm_req    = 1'b0;
        mem_ready = 1'b0;
        step;

        // Starvation: fetch held off only in dm_done cycles so data keeps winning
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h300;
        if_req    = 1'b1;
        if_addr   = 32'h48;
        mem_ready = 1'b1;
        mem_rdata = 32'h99;
        dg = 0;
        dg_at_fetch = -1;
        seen_i = 1'b0;
        streak_at_fetch = 32'hFFFF_FFFF;
        for (int c = 0; c < 40 && !seen_i; c++) begin
            step;
            if (mem_req) begin
                if (mem_addr == 32'h48) begin
                    seen_i = 1'b1;
                    dg_at_fetch = dg;
                    streak_at_fetch = 32'(dut.u_streak.cnt_q);
                end else begin
                    dg++;
                end
            end
            if_req = !dm_done;
        end
        chk("s_fetch_seen",   32'(seen_i),      32'd1);
        chk("s_data_grants",  32'(dg_at_fetch), 32'd4);
        chk("s_streak_clear", streak_at_fetch,  32'd0);
        dm_req = 1'b0;
        if_req = 1'b0;
        step;
        step;
        step;
        // mem_ready still high while IDLE
        chk("i_idle_req", 32'(mem_req), 32'd0);
        chk("i_idle_id",  32'(if_done), 32'd0);
        chk("i_idle_dd",  32'(dm_done), 32'd0);

        // Reset in the middle of a fetch
        mem_ready = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h80;
        step;
        chk("r_busy", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_async_req",  32'(mem_req), 32'd0);
        chk("r_async_addr", mem_addr,     32'd0);
        mem_ready = 1'b1;
        step;
        chk("r_no_done", 32'(if_done), 32'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        step;
        chk("r_regrant",  32'(mem_req), 32'd1);
        chk("r_addr",     mem_addr,     32'h80);
        chk("r_no_done2", 32'(if_done), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD;
        step;
        chk("r_done",  32'(if_done), 32'd1);
        chk("r_rdata", if_rdata,     32'hDEAD);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4: consecutive data grants allowed while fetch waits.
REQ-002 SHALL have parameter AW, default 32: address/data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_req  input  1, and if_addr  input  AW: fetch request and address.
REQ-006 SHALL have ports if_rdata  output  AW, and if_done  output  1: fetch data and one-cycle completion pulse.
REQ-007 SHALL have ports dm_req, dm_we  input  1, and dm_addr, dm_wdata  input  AW: data-memory request, write enable, address, write data.
REQ-008 SHALL have ports dm_rdata  output  AW, and dm_done  output  1: load data and one-cycle completion pulse.
REQ-009 SHALL have ports mem_req, mem_we  output  1, and mem_addr, mem_wdata  output  AW: shared single-port memory request.
REQ-010 SHALL have ports mem_rdata  input  AW, and mem_ready  input  1: memory read data and completion.
REQ-011 SHALL have port mem_stall  output  1: pipeline stall request, consumed by hazard logic as extra StallF/StallD source.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-013 In IDLE, SHALL arbitrate each cycle: dm_req only -> BUSY_D; if_req only -> BUSY_I; both -> BUSY_D unless streak == MAX_DATA_STREAK, then BUSY_I; none -> stay IDLE.
REQ-014 On grant, SHALL register the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata (mem_we = 0 for fetch) and hold them constant through the BUSY state.
REQ-015 mem_req SHALL be 1 exactly in BUSY_I/BUSY_D, 0 in IDLE.
REQ-016 In BUSY_x with mem_ready = 1, SHALL register mem_rdata into x_rdata, pulse x_done for exactly the next cycle, and return to IDLE.
REQ-017 In BUSY_x with mem_ready = 0, SHALL remain in BUSY_x with no timeout.
REQ-018 Minimum latency: request seen in IDLE cycle N, mem_ready in N+1 -> done in N+2.
REQ-019 x_rdata SHALL hold its last value until the next completion for x; for data writes, dm_rdata SHALL be loaded with mem_rdata regardless.
REQ-020 A requester's req SHALL be ignored in the cycle its done is high; no duplicate grant.
REQ-021 The other requester's pending req SHALL be eligible in that same done cycle: back-to-back grant, no idle bubble.
REQ-022 The streak counter SHALL increment, saturating at MAX_DATA_STREAK, on a data grant while if_req = 1.
REQ-023 The streak counter SHALL clear on any fetch grant, or on a data grant while if_req = 0.
REQ-024 mem_stall SHALL equal (if_req & ~if_done) | (dm_req & ~dm_done), combinationally.
REQ-025 SHALL ignore mem_ready while in IDLE.

Reset
REQ-026 On rst_n low, SHALL immediately enter IDLE and drive mem_req, mem_we, if_done, dm_done = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; streak = 0.
REQ-027 Reset mid-transaction SHALL abandon the access without a done pulse; the memory tolerates mem_req dropping early.
REQ-028 First arbitration SHALL occur in the first clk edge after rst_n deasserts.

Structure
REQ-029 The FSM state encoding and default MAX_DATA_STREAK SHALL live in the shared mips_defs package.
REQ-030 The streak counter SHALL be a sub-module arb_streak_ctr (inc, clr, sat output); all other logic stays in mem_port_arbiter.

Verification
REQ-031 Fetch only: if_req = 1, if_addr = 0x40, mem_ready one cycle after mem_req, mem_rdata = 0x8C010004 -> if_done in N+2, if_rdata = 0x8C010004, mem_we = 0.
REQ-032 Contention: if_req and dm_req both 1, dm_we = 1, dm_addr = 0x100, dm_wdata = 0xAB -> data served first, then fetch granted in the dm_done cycle; mem_stall stays 1 until if_done.
REQ-033 Starvation: dm_req held 1 with if_req = 1 and mem_ready every cycle -> exactly 4 data grants, then 1 fetch grant, streak back to 0.
REQ-034 Wait states: mem_ready low for 5 cycles in BUSY_D -> mem_addr/mem_wdata stable, no done, mem_stall = 1 throughout.
REQ-035 Reset mid-BUSY_I: rst_n low -> mem_req = 0 asynchronously, no if_done pulse, after release a fresh if_req is granted normally.
REQ-036 Done-cycle hold: requester keeps req = 1 during its done cycle -> no second grant for that request.
